// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int         CNT_W     = 8;
  localparam int         DEF_PAT_W = 4;
  localparam logic [3:0] DEF_PAT   = 4'b1101;

  // Width needed to hold a count from 0 up to and including pat_w.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_window.sv
// Sliding window of recent valid bits with a saturating fill count.
// Presents the candidate word (history plus incoming bit) to the comparator.
module seq_window
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift,
  input  logic             in,
  output logic [PAT_W-1:0] cand,
  output logic             primed,
  output logic             full
);

  localparam int FW = fill_width(PAT_W);

  // Only the newest PAT_W-1 bits are kept: the oldest bit of a full window
  // is shifted out by the incoming bit before it could ever be compared.
  logic [PAT_W-2:0] hist_reg;
  logic [FW-1:0]    fill_reg;

  assign cand   = {hist_reg, in};
  assign primed = (fill_reg >= FW'(PAT_W - 1));
  assign full   = (fill_reg == FW'(PAT_W));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (shift) begin
      hist_reg <= cand[PAT_W-2:0];
      if (!full) begin
        fill_reg <= fill_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detector_p.sv
// Serial pattern detector with a runtime-loadable pattern and overlap option.
// Define SEQ_DETECTOR_P_MATCH_CNT_EN to add the saturating match_cnt output.
module seq_detector_p
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = DEF_PAT_W,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(DEF_PAT),
  parameter bit               OVERLAP     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             out,
  output logic             busy_fill
`ifdef SEQ_DETECTOR_P_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  logic [PAT_W-1:0] pattern_reg;
  logic             out_reg;
  logic [PAT_W-1:0] cand;
  logic             primed;
  logic             full;
  logic             win_shift;
  logic             win_clear;
  logic             hit;

  // A load in the same cycle as a valid bit discards that bit.
  assign win_shift = in_valid && !pat_load;
  assign hit       = win_shift && primed && (cand == pattern_reg);
  assign win_clear = pat_load || (hit && !OVERLAP);

  seq_window #(
    .PAT_W(PAT_W)
  ) u_window (
    .clk   (clk),
    .reset (reset),
    .clear (win_clear),
    .shift (win_shift),
    .in    (in),
    .cand  (cand),
    .primed(primed),
    .full  (full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_reg <= DEFAULT_PAT;
      out_reg     <= 1'b0;
    end else if (pat_load) begin
      pattern_reg <= pat_in;
      out_reg     <= 1'b0;
    end else begin
      out_reg     <= hit;
    end
  end

  assign out       = out_reg;
  assign busy_fill = !full;

`ifdef SEQ_DETECTOR_P_MATCH_CNT_EN
  logic [CNT_W-1:0] match_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      match_cnt_reg <= '0;
    end else if (hit && (match_cnt_reg != {CNT_W{1'b1}})) begin
      match_cnt_reg <= match_cnt_reg + 1'b1;
    end
  end

  assign match_cnt = match_cnt_reg;
`endif

endmodule

// File: tb/tb_seq_detector_p.sv
// Bench for seq_detector_p: three instances (overlap, non-overlap, 2-bit)
// share one stimulus stream and are checked against a bit-list reference model.
module tb_seq_detector_p;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in = 1'b0;
  logic       in_valid = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'd0;

  logic out0, busy0, out1, busy1, out2, busy2;
  logic [7:0] cnt0, cnt1, cnt2;

  always #5 clk = ~clk;

  seq_detector_p #(.PAT_W(4), .DEFAULT_PAT(4'b1101), .OVERLAP(1'b1)) dut0 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .pat_load(pat_load), .pat_in(pat_in), .out(out0), .busy_fill(busy0)
`ifdef SEQ_DETECTOR_P_MATCH_CNT_EN
    , .match_cnt(cnt0)
`endif
  );

  seq_detector_p #(.PAT_W(4), .DEFAULT_PAT(4'b1101), .OVERLAP(1'b0)) dut1 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .pat_load(pat_load), .pat_in(pat_in), .out(out1), .busy_fill(busy1)
`ifdef SEQ_DETECTOR_P_MATCH_CNT_EN
    , .match_cnt(cnt1)
`endif
  );

  seq_detector_p #(.PAT_W(2), .DEFAULT_PAT(2'b11), .OVERLAP(1'b1)) dut2 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .pat_load(pat_load), .pat_in(pat_in[1:0]), .out(out2), .busy_fill(busy2)
`ifdef SEQ_DETECTOR_P_MATCH_CNT_EN
    , .match_cnt(cnt2)
`endif
  );

`ifndef SEQ_DETECTOR_P_MATCH_CNT_EN
  assign cnt0 = 8'd0;
  assign cnt1 = 8'd0;
  assign cnt2 = 8'd0;
`endif

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: the list of valid bits seen since the last clear event.
  int m_w[3]   = '{4, 4, 2};
  bit m_ov[3]  = '{1'b1, 1'b0, 1'b1};
  int m_def[3] = '{13, 13, 3};
  int m_pat[3] = '{13, 13, 3};
  int m_n[3]   = '{0, 0, 0};
  int m_cnt[3] = '{0, 0, 0};
  bit m_out[3] = '{1'b0, 1'b0, 1'b0};
  bit m_buf[3][64];

  task automatic model_step();
    bit hit;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_pat[k] = m_def[k];
        m_n[k]   = 0;
        m_out[k] = 1'b0;
        m_cnt[k] = 0;
      end else if (pat_load) begin
        m_pat[k] = int'(pat_in) % (1 << m_w[k]);
        m_n[k]   = 0;
        m_out[k] = 1'b0;
      end else if (in_valid) begin
        if (m_n[k] == 64) begin
          for (int j = 0; j < 63; j++) m_buf[k][j] = m_buf[k][j+1];
          m_n[k] = 63;
        end
        m_buf[k][m_n[k]] = in;
        m_n[k]++;
        hit = (m_n[k] >= m_w[k]);
        for (int j = 0; j < m_w[k]; j++)
          if (hit && (m_buf[k][m_n[k]-1-j] != m_pat[k][j])) hit = 1'b0;
        m_out[k] = hit;
        if (hit && m_cnt[k] < 255) m_cnt[k]++;
        if (hit && !m_ov[k]) m_n[k] = 0;
      end else begin
        m_out[k] = 1'b0;
      end
    end
  endtask

  function automatic logic get_out(int k);
    return (k == 0) ? out0 : (k == 1) ? out1 : out2;
  endfunction

  function automatic logic get_busy(int k);
    return (k == 0) ? busy0 : (k == 1) ? busy1 : busy2;
  endfunction

  function automatic int get_cnt(int k);
    return (k == 0) ? int'(cnt0) : (k == 1) ? int'(cnt1) : int'(cnt2);
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    in = b;
    in_valid = 1'b1;
    pat_load = 1'b0;
    reset = 1'b0;
    cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    pat_load = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in = 1'b1;
    in_valid = 1'b1;
    pat_load = 1'b1;
    pat_in = 4'b0000;
    cycle();
    reset = 1'b0;
    in_valid = 1'b0;
    pat_load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (get_out(k) !== 1'b0 || get_busy(k) !== 1'b1 || get_cnt(k) != 0)
        $display("FAIL reset inst%0d: out=%b busy=%b cnt=%0d required out=0 busy=1 cnt=0",
                 k, get_out(k), get_busy(k), get_cnt(k));
      else n_pass++;
    end
    $display("test_reset done");
  endtask

  task automatic test_overlap();
    logic [9:0] stream = 10'b1101101101;
    logic e0, e1, eb0;
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      send(stream[10-i]);
      e0  = (i == 4 || i == 7 || i == 10);
      e1  = (i == 4 || i == 10);
      eb0 = (i < 4);
      n_checks++;
      if (out0 !== e0 || out1 !== e1 || busy0 !== eb0)
        $display("FAIL overlap bit%0d: out0=%b out1=%b busy0=%b required %b %b %b",
                 i, out0, out1, busy0, e0, e1, eb0);
      else n_pass++;
      if (i == 4) begin
        n_checks++;
        if (busy1 !== 1'b1) $display("FAIL nonoverlap_busy: busy1=%b required 1", busy1);
        else n_pass++;
      end
      $display("overlap bit%0d in=%b out0=%b out1=%b", i, stream[10-i], out0, out1);
    end
`ifdef SEQ_DETECTOR_P_MATCH_CNT_EN
    n_checks++;
    if (cnt0 !== 8'd3 || cnt1 !== 8'd2)
      $display("FAIL overlap_cnt: cnt0=%0d cnt1=%0d required 3 2", cnt0, cnt1);
    else n_pass++;
`endif
  endtask

  task automatic test_gaps();
    bit vv[7] = '{1, 1, 0, 0, 0, 1, 1};
    bit bb[7] = '{1, 1, 0, 1, 0, 0, 1};
    logic e0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      in = bb[i];
      in_valid = vv[i];
      cycle();
      e0 = (i == 6);
      n_checks++;
      if (out0 !== e0 || busy0 !== (i != 6))
        $display("FAIL gaps step%0d: out0=%b busy0=%b required %b %b", i, out0, busy0, e0, i != 6);
      else n_pass++;
      $display("gaps step%0d valid=%b in=%b out0=%b", i, vv[i], bb[i], out0);
    end
  endtask

  task automatic test_reload();
    bit bb[4] = '{0, 1, 1, 1};
    do_reset();
    send(1'b1); send(1'b1); send(1'b0);
    in = 1'b1;
    in_valid = 1'b1;
    pat_load = 1'b1;
    pat_in = 4'b0111;
    cycle();
    pat_load = 1'b0;
    n_checks++;
    if (out0 !== 1'b0 || busy0 !== 1'b1)
      $display("FAIL reload_load: out0=%b busy0=%b required 0 1", out0, busy0);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      send(bb[i]);
      n_checks++;
      if (out0 !== (i == 3)) $display("FAIL reload bit%0d: out0=%b required %b", i, out0, i == 3);
      else n_pass++;
      $display("reload bit%0d in=%b out0=%b", i, bb[i], out0);
    end
  endtask

  task automatic test_midreset();
    bit bb[5] = '{1, 1, 1, 0, 1};
    do_reset();
    send(1'b1); send(1'b1); send(1'b0);
    reset = 1'b1;
    in = 1'b1;
    in_valid = 1'b1;
    cycle();
    reset = 1'b0;
    n_checks++;
    if (out0 !== 1'b0 || busy0 !== 1'b1 || cnt0 !== 8'd0)
      $display("FAIL midreset: out0=%b busy0=%b cnt0=%0d required 0 1 0", out0, busy0, cnt0);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      send(bb[i]);
      n_checks++;
      if (out0 !== (i == 4)) $display("FAIL midreset bit%0d: out0=%b required %b", i, out0, i == 4);
      else n_pass++;
      $display("midreset bit%0d in=%b out0=%b", i, bb[i], out0);
    end
  endtask

  task automatic test_saturation();
    int highs = 0;
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      send(1'b1);
      if (out2 === 1'b1) highs++;
      n_checks++;
      if (out2 !== (i >= 2) || out0 !== 1'b0)
        $display("FAIL saturation bit%0d: out2=%b out0=%b required %b 0", i, out2, out0, i >= 2);
      else n_pass++;
    end
    n_checks++;
    if (highs != 299) $display("FAIL saturation_run: highs=%0d required 299", highs);
    else n_pass++;
`ifdef SEQ_DETECTOR_P_MATCH_CNT_EN
    n_checks++;
    if (cnt2 !== 8'd255) $display("FAIL saturation_cnt: cnt2=%0d required 255", cnt2);
    else n_pass++;
`endif
    $display("saturation highs=%0d cnt2=%0d", highs, cnt2);
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      pat_load = ($urandom_range(0, 39) == 0);
      pat_in   = 4'($urandom_range(0, 15));
      in_valid = ($urandom_range(0, 3) != 0);
      in       = 1'($urandom_range(0, 1));
      cycle();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (get_out(k) !== m_out[k] || get_busy(k) !== (m_n[k] < m_w[k])
`ifdef SEQ_DETECTOR_P_MATCH_CNT_EN
            || get_cnt(k) != m_cnt[k]
`endif
           ) begin
          if (errs < 20)
            $display("FAIL random cyc%0d inst%0d: out=%b busy=%b cnt=%0d required %b %b %0d",
                     i, k, get_out(k), get_busy(k), get_cnt(k), m_out[k], m_n[k] < m_w[k], m_cnt[k]);
          errs++;
        end else n_pass++;
      end
      if (i % 250 == 0)
        $display("random cyc%0d rst=%b ld=%b v=%b in=%b out=%b%b%b", i, reset, pat_load,
                 in_valid, in, out0, out1, out2);
    end
    reset = 1'b0;
    pat_load = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_overlap();
    test_gaps();
    test_reload();
    test_midreset();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_detector_p.md
Name: seq_detector_p

Overview:
- Parametrised serial pattern detector; successor to the fixed 3-bit string detector.
- Watches a 1-bit serial stream qualified by a valid strobe and compares the last PAT_W valid bits against a runtime-loadable pattern.
- Emits a one-cycle match pulse, in overlapping or non-overlapping mode.
- Sits between the serial input stage and the control logic that consumes match events.

Parameters:
- PAT_W, 4, pattern length in bits (2..16).
- DEFAULT_PAT, 4'b1101, pattern loaded at reset (PAT_W bits); the first-received bit is the MSB.
- OVERLAP, 1, 1 = overlapping detection; 0 = the history restarts after each match.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  1  serial data bit.
- in_valid  input  1  `in` is sampled only when this is high.
- pat_load  input  1  load `pat_in` as the new pattern.
- pat_in  input  PAT_W  new pattern value, MSB is the first-received bit.
- out  output  1  registered match pulse.
- busy_fill  output  1  high while fewer than PAT_W valid bits are held since the last reset, load, or non-overlap match.

Behaviour:
- Reset (clk edge with reset=1): pattern<=DEFAULT_PAT; hist<=0; fill<=0; out<=0; counter<=0 if compiled in. Reset has priority over every other input.
- State:
  - hist[PAT_W-1:0]: shift register, newest bit in the LSB.
  - fill: saturating count 0..PAT_W, width $clog2(PAT_W+1).
  - pattern register.
- Edge with pat_load=1, reset=0: pattern<=pat_in; hist<=0; fill<=0; out<=0. Any `in_valid` in the same cycle is ignored (the load wins).
- Edge with in_valid=1, pat_load=0, reset=0:
  - cand = {hist[PAT_W-2:0], in}.
  - hit = (fill >= PAT_W-1) && (cand == pattern).
  - out <= hit.
  - If hit && OVERLAP==0: hist<=0 and fill<=0.
  - Otherwise: hist<=cand and fill<=min(fill+1, PAT_W).
- Edge with in_valid=0, pat_load=0, reset=0: hist and fill hold; out<=0.
- Latency and pulse width:
  - `out` is high for exactly one clk period, starting at the edge that samples the completing bit.
  - Back-to-back pulses are possible in overlap mode, e.g. pattern 2'b11 with continuous 1s.
- busy_fill = (fill < PAT_W), combinational from `fill`.
- Reset mid-stream discards all partial history. No match can be reported until PAT_W new valid bits have arrived.

Optional Feature:
- Macro: SEQ_DETECTOR_P_MATCH_CNT_EN.
- When defined:
  - Adds output match_cnt [7:0].
  - The counter increments on every edge where hit=1.
  - It saturates at 8'd255 and clears on reset.
  - pat_load does not clear it.
- When undefined: the port and counter do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package seq_det_pkg:
  - localparam CNT_W = 8;
  - a function for the fill-width calculation;
  - the default PAT_W/DEFAULT_PAT values.
- One natural sub-module, seq_window:
  - holds the hist/fill shift window with a clear input;
  - outputs the candidate word and a window-full flag.
- seq_detector_p holds the pattern register, the compare, the out register and the optional counter.

Test Plan:
1. Overlap (PAT_W=4, pattern 1101): stream 1101101101, in_valid=1 every cycle -> out pulses after bits 4, 7 and 10; match_cnt=3.
2. Non-overlap (OVERLAP=0): same stream -> out pulses after bits 4 and 10 only; busy_fill is high again right after bit 4.
3. Valid gaps: bits 1,1 then in_valid=0 for 3 cycles (in toggling), then 0,1 -> a single pulse after the 4th valid bit; out=0 during the gap.
4. Mid-stream reload: after 110, assert pat_load with pat_in=0111 together with in_valid=1, in=1 -> no pulse, fill=0; then stream 0111 -> pulse after the 4th bit.
5. Mid-stream reset: send 110, reset 1 cycle, send 1 -> no pulse; out=0 and match_cnt=0 after reset; then 1101 -> pulse.
6. Saturation (macro on, PAT_W=2, pattern 11, overlap): 300 consecutive 1s -> out is high on 299 consecutive cycles; match_cnt holds at 255.
